nibble_serial_add_ctrl: RTL
===========================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 WIDTH, 16, operand/result width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to the least significant nibble.
REQ-009 out_valid  output  1  sum and cout are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry-out of the most significant nibble.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-016 Accept happens on in_valid && in_ready: latch a, b and cin into internal registers, clear the nibble index to 0, and go to RUN.
REQ-017 Each RUN cycle SHALL add nibble[idx] of A and B plus the carry register through a single 4-bit adder.
REQ-018 That cycle SHALL write the 4-bit result into sum[4*idx+3:4*idx], update the carry register, and increment idx.
REQ-019 The carry register SHALL be loaded with cin at accept.
REQ-020 After the final nibble (idx = WIDTH/4-1), the FSM SHALL go to DONE and cout SHALL equal the final carry.
REQ-021 out_valid SHALL rise exactly WIDTH/4 rising edges after the accepting edge; WIDTH=4 gives 1.
REQ-022 In DONE, sum and cout SHALL hold stable until out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-023 in_ready SHALL rise the cycle after the output handshake; there is no same-cycle bypass.
REQ-024 in_valid while not in IDLE SHALL be ignored; a, b and cin SHALL be sampled only at accept.
REQ-025 Operand changes after accept SHALL NOT affect the result.
REQ-026 sum bits for unprocessed nibbles are don't-care outside DONE.
REQ-027 The result SHALL equal (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH of the sum.

Reset
REQ-028 While rst is high: state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=0.
REQ-029 Assertion of rst mid-RUN or in DONE SHALL abort the operation immediately with no result produced.
REQ-030 in_ready SHALL go high on the first cycle after rst deasserts.

Configuration
REQ-031 Macro NIBBLE_SERIAL_SUBTRACT_EN SHALL control subtract support.
REQ-032 When NIBBLE_SERIAL_SUBTRACT_EN is defined: add input port sub (1 bit), latched at accept.
REQ-033 When sub=1, B nibbles SHALL be inverted before the adder, the carry register SHALL load 1 (cin ignored), and the result is a - b mod 2^WIDTH.
REQ-034 In subtract mode, cout=1 means no borrow.
REQ-035 When NIBBLE_SERIAL_SUBTRACT_EN is undefined: no sub port, add only; behaviour is identical to sub=0.

Structure
REQ-036 Shared package nibble_pkg SHALL hold the FSM state enum typedef and the constant NIBBLE_W=4.
REQ-037 The 4-bit adder SHALL be a sub-module, nibble_adder, with ports a[3:0], b[3:0], ci, s[3:0], co; purely combinational ripple-carry; one instance.

Verification (WIDTH=16)
REQ-038 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 edges after accept.
REQ-039 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all nibble boundaries).
REQ-040 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
REQ-041 Hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands -> sum/cout unchanged, in_ready=0, new operands ignored; after the handshake, in_ready=1 the next cycle.
REQ-042 Assert rst after 2 RUN cycles -> all outputs 0 and state IDLE; next operation a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
REQ-043 With NIBBLE_SERIAL_SUBTRACT_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit purely combinational ripple-carry adder.
module nibble_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that processes one nibble per cycle through a single 4-bit adder.
// Optional subtract support is enabled by defining NIBBLE_SERIAL_SUBTRACT_EN.
module nibble_serial_add_ctrl
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q, cout_q, sub_q;
  logic               sub_in, accept, last;
  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic               co_nib;

`ifdef NIBBLE_SERIAL_SUBTRACT_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // in_ready is masked by rst so it stays low for the whole reset assertion.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == LAST_IDX);

  assign a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
  assign b_nib = sub_q ? ~b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W]
                       :  b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];

  nibble_adder u_adder (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub_in;
      idx_q   <= '0;
      carry_q <= sub_in ? 1'b1 : cin;
    end else if (state_q == RUN) begin
      sum_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] <= s_nib;
      carry_q <= co_nib;
      if (last) begin
        cout_q <= co_nib;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
